// File: rtl/aes_round_ops_if.sv
// Bus bundle for the three AES-128 round-step channels (AddRoundKey, ShiftRows, MixColumns).
// The controller drives the master side and the round-step block sits on the slave side.
interface aes_round_ops_if;
  logic [127:0] ark_state;
  logic [127:0] ark_key;
  logic         ark_en;
  logic [127:0] ark_out;
  logic         ark_done;
  logic [127:0] sr_data;
  logic         sr_en;
  logic [127:0] sr_out;
  logic         sr_done;
  logic [127:0] mc_state;
  logic         mc_en;
  logic [127:0] mc_out;
  logic         mc_done;

  modport master (
    output ark_state, ark_key, ark_en, sr_data, sr_en, mc_state, mc_en,
    input  ark_out, ark_done, sr_out, sr_done, mc_out, mc_done
  );

  modport slave (
    input  ark_state, ark_key, ark_en, sr_data, sr_en, mc_state, mc_en,
    output ark_out, ark_done, sr_out, sr_done, mc_out, mc_done
  );
endinterface

// File: rtl/aes_round_ops.sv
// AES-128 AddRoundKey, ShiftRows and MixColumns, each a single registered channel
// with an independent enable/done handshake. Byte 0 is the MSB byte; state is column-major.
module aes_round_ops (
  input  logic          clk,
  input  logic          rst,
  aes_round_ops_if.slave bus
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      res[127-32*c -: 32] = mixColumn(st[127-32*c -: 32]);
    return res;
  endfunction

  // Output byte s'[r][c] takes s[r][(c+r) mod 4]; row r rotates left by r bytes.
  function automatic logic [127:0] shiftRows(input logic [127:0] st);
    logic [127:0] res;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+r)%4)) -: 8];
    return res;
  endfunction

  logic [127:0] arkOut_p0;
  logic [127:0] srOut_p0;
  logic [127:0] mcOut_p0;
  logic         arkVld_p0;
  logic         srVld_p0;
  logic         mcVld_p0;

  // Stage p0: result registered on the edge that samples en; done mirrors the sampled en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arkOut_p0 <= '0;
      srOut_p0  <= '0;
      mcOut_p0  <= '0;
      arkVld_p0 <= 1'b0;
      srVld_p0  <= 1'b0;
      mcVld_p0  <= 1'b0;
    end else begin
      arkVld_p0 <= bus.ark_en;
      srVld_p0  <= bus.sr_en;
      mcVld_p0  <= bus.mc_en;
      if (bus.ark_en) arkOut_p0 <= bus.ark_state ^ bus.ark_key;
      if (bus.sr_en)  srOut_p0  <= shiftRows(bus.sr_data);
      if (bus.mc_en)  mcOut_p0  <= mixColumns(bus.mc_state);
    end
  end

  assign bus.ark_out  = arkOut_p0;
  assign bus.ark_done = arkVld_p0;
  assign bus.sr_out   = srOut_p0;
  assign bus.sr_done  = srVld_p0;
  assign bus.mc_out   = mcOut_p0;
  assign bus.mc_done  = mcVld_p0;

endmodule

// File: tb/tb_aes_round_ops.sv
// Directed-vector bench for aes_round_ops: FIPS-197 round-step vectors, handshake
// timing, channel concurrency and asynchronous reset.
module tb_aes_round_ops;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  aes_round_ops_if bus ();

  aes_round_ops dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           ch;     // 0 = AddRoundKey, 1 = ShiftRows, 2 = MixColumns
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[7];

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outOf(input int ch);
    case (ch)
      0:       return bus.ark_out;
      1:       return bus.sr_out;
      default: return bus.mc_out;
    endcase
  endfunction

  function automatic logic doneOf(input int ch);
    case (ch)
      0:       return bus.ark_done;
      1:       return bus.sr_done;
      default: return bus.mc_done;
    endcase
  endfunction

  task automatic drive(input int ch, input logic [127:0] a, input logic [127:0] b, input logic en);
    case (ch)
      0: begin bus.ark_state = a; bus.ark_key = b; bus.ark_en = en; end
      1: begin bus.sr_data = a; bus.sr_en = en; end
      default: begin bus.mc_state = a; bus.mc_en = en; end
    endcase
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int ch = 0; ch < 3; ch++) begin
      check128($sformatf("%s_out%0d", tag, ch), outOf(ch), 128'h0);
      check1($sformatf("%s_done%0d", tag, ch), doneOf(ch), 1'b0);
    end
  endtask

  localparam logic [127:0] ARK_S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ARK_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ARK_R = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SR_I  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SR_R  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_I  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_R  = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{0, ARK_S, ARK_K, ARK_R, "ark_fips"};
    vecs[1] = '{0, 128'hffffffffffffffffffffffffffffffff, 128'h0123456789abcdeffedcba9876543210,
                128'hfedcba98765432100123456789abcdef, "ark_ones"};
    vecs[2] = '{1, SR_I, 128'h0, SR_R, "sr_fips"};
    vecs[3] = '{1, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                128'h00050a0f04090e03080d02070c01060b, "sr_index"};
    vecs[4] = '{2, MC_I, 128'h0, MC_R, "mc_fips"};
    vecs[5] = '{2, 128'hdb135345f20a225c01010101c6c6c6c6, 128'h0,
                128'h8e4da1bc9fdc589d01010101c6c6c6c6, "mc_columns"};
    vecs[6] = '{2, 128'hd4d4d4d52d26314c0000000080808080, 128'h0,
                128'hd5d5d7d64d7ebdf80000000080808080, "mc_more"};

    rst = 1'b1;
    for (int ch = 0; ch < 3; ch++) drive(ch, 128'h0, 128'h0, 1'b0);
    #12;
    checkAllZero("reset");
    stepEdge();
    rst = 1'b0;
    stepEdge();
    checkAllZero("post_reset_idle");

    // Single-edge enable pulse per vector: done high exactly one cycle, output then holds.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].ch, vecs[i].a, vecs[i].b, 1'b1);
      stepEdge();
      check128({vecs[i].name, "_out"}, outOf(vecs[i].ch), vecs[i].exp);
      check1({vecs[i].name, "_done"}, doneOf(vecs[i].ch), 1'b1);
      drive(vecs[i].ch, 128'h0, 128'h0, 1'b0);
      stepEdge();
      check1({vecs[i].name, "_done_fall"}, doneOf(vecs[i].ch), 1'b0);
      check128({vecs[i].name, "_hold"}, outOf(vecs[i].ch), vecs[i].exp);
    end

    // Enable held three cycles with the input changing each cycle.
    drive(0, ARK_S, ARK_K, 1'b1);
    stepEdge();
    check128("hold_c1_out", bus.ark_out, ARK_R);
    check1("hold_c1_done", bus.ark_done, 1'b1);
    drive(0, 128'h00ff00ff00ff00ff00ff00ff00ff00ff, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1);
    stepEdge();
    check128("hold_c2_out", bus.ark_out, 128'h0ff00ff00ff00ff00ff00ff00ff00ff0);
    check1("hold_c2_done", bus.ark_done, 1'b1);
    drive(0, ARK_S, 128'h0, 1'b1);
    stepEdge();
    check128("hold_c3_out", bus.ark_out, ARK_S);
    check1("hold_c3_done", bus.ark_done, 1'b1);
    drive(0, 128'h0, 128'h0, 1'b0);
    stepEdge();
    check1("hold_done_fall", bus.ark_done, 1'b0);
    check128("hold_out_keep", bus.ark_out, ARK_S);

    // All three channels enabled on the same edge.
    drive(0, ARK_S, ARK_K, 1'b1);
    drive(1, SR_I, 128'h0, 1'b1);
    drive(2, MC_I, 128'h0, 1'b1);
    stepEdge();
    check128("conc_ark", bus.ark_out, ARK_R);
    check128("conc_sr", bus.sr_out, SR_R);
    check128("conc_mc", bus.mc_out, MC_R);
    check1("conc_ark_done", bus.ark_done, 1'b1);
    check1("conc_sr_done", bus.sr_done, 1'b1);
    check1("conc_mc_done", bus.mc_done, 1'b1);

    // Asynchronous reset mid-cycle with every enable still high.
    #3;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    stepEdge();
    checkAllZero("reset_held");
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("reset_released");
    stepEdge();
    check128("restart_ark", bus.ark_out, ARK_R);
    check128("restart_sr", bus.sr_out, SR_R);
    check128("restart_mc", bus.mc_out, MC_R);
    check1("restart_ark_done", bus.ark_done, 1'b1);
    check1("restart_sr_done", bus.sr_done, 1'b1);
    check1("restart_mc_done", bus.mc_done, 1'b1);
    for (int ch = 0; ch < 3; ch++) drive(ch, 128'h0, 128'h0, 1'b0);
    stepEdge();
    check1("final_ark_done", bus.ark_done, 1'b0);
    check1("final_sr_done", bus.sr_done, 1'b0);
    check1("final_mc_done", bus.mc_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
